// File: rtl/vram_write_queue_m_if.sv
// CPU-side write/fill request bus and VRAM write port of the VRAM write queue.
// The queue is the slave; the CPU decode / video timing side is the master.
interface vram_write_queue_m_if #(
  parameter int unsigned AW = 12
);
  logic          writable;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [AW-1:0] cpu_address;
  logic [7:0]    cpu_data;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW-1:0] fill_len;
  logic [7:0]    fill_value;
  logic          busy;
  logic          overflow;
  logic          vram_we;
  logic [AW-1:0] vram_address;
  logic [7:0]    vram_data;

  modport master (
    output writable, cpu_valid, cpu_address, cpu_data,
    output fill_start, fill_base, fill_len, fill_value,
    input  cpu_ready, busy, overflow, vram_we, vram_address, vram_data
  );

  modport slave (
    input  writable, cpu_valid, cpu_address, cpu_data,
    input  fill_start, fill_base, fill_len, fill_value,
    output cpu_ready, busy, overflow, vram_we, vram_address, vram_data
  );
endinterface

// File: rtl/vram_write_queue_m.sv
// Buffers CPU byte writes to VRAM and issues them, or hardware block fills,
// only while the video timing reports the write window open.
module vram_write_queue_m #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 12
) (
  input logic                 clk,
  input logic                 rst,
  vram_write_queue_m_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_WAIT = 2'd1,
    FILL      = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [AW+7:0]  mem_q [DEPTH];
  logic [PW:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count, count_d;
  logic           full, empty;
  logic           push, pop, fill_issue, fill_latch;
  logic           overflow_q;
  logic           vram_we_q;
  logic [AW-1:0]  vram_address_q;
  logic [7:0]     vram_data_q;
  logic [AW-1:0]  fill_cur_q, fill_rem_q;
  logic [7:0]     fill_val_q;
  logic [AW-1:0]  head_address;
  logic [7:0]     head_data;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign {head_address, head_data} = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    state_d    = state_q;
    push       = bus.cpu_valid && !full;
    pop        = (state_q != FILL) && bus.writable && !empty;
    fill_issue = 1'b0;
    fill_latch = 1'b0;
    count_d    = count + (PW+1)'(push) - (PW+1)'(pop);
    // Emptiness is judged after this edge's push/pop, so a same-cycle push defers the fill.
    case (state_q)
      IDLE: begin
        if (bus.fill_start && (bus.fill_len != '0)) begin
          fill_latch = 1'b1;
          state_d    = (count_d == '0) ? FILL : FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (count_d == '0) state_d = FILL;
      end
      FILL: begin
        if (bus.writable) begin
          fill_issue = 1'b1;
          if (fill_rem_q == AW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {bus.cpu_address, bus.cpu_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      vram_we_q      <= 1'b0;
      vram_address_q <= '0;
      vram_data_q    <= '0;
      fill_cur_q     <= '0;
      fill_rem_q     <= '0;
      fill_val_q     <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_q | (bus.cpu_valid & full);
      vram_we_q  <= pop | fill_issue;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + 1'b1;
        vram_address_q <= head_address;
        vram_data_q    <= head_data;
      end else if (fill_issue) begin
        vram_address_q <= fill_cur_q;
        vram_data_q    <= fill_val_q;
      end
      if (fill_latch) begin
        fill_cur_q <= bus.fill_base;
        fill_rem_q <= bus.fill_len;
        fill_val_q <= bus.fill_value;
      end else if (fill_issue) begin
        fill_cur_q <= fill_cur_q + 1'b1;
        fill_rem_q <= fill_rem_q - 1'b1;
      end
    end
  end

  assign bus.cpu_ready    = !full;
  assign bus.busy         = (state_q != IDLE) || !empty;
  assign bus.overflow     = overflow_q;
  assign bus.vram_we      = vram_we_q;
  assign bus.vram_address = vram_address_q;
  assign bus.vram_data    = vram_data_q;

endmodule

// File: tb/tb_vram_write_queue_m.sv
// Directed bench for vram_write_queue_m: queued writes, overflow, fills with
// write-window gating, address wrap, fill deferral and reset abandonment.
module tb_vram_write_queue_m;

  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_bad;

  vram_write_queue_m_if #(.AW(12)) bus();

  vram_write_queue_m #(.DEPTH(16), .AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned n;
    logic [11:0] ea;
    logic        wprev;
    logic [11:0] wrap_addr [4];

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.writable    = 1'b0;
    bus.cpu_valid   = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_data    = '0;
    bus.fill_start  = 1'b0;
    bus.fill_base   = '0;
    bus.fill_len    = '0;
    bus.fill_value  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_we",       32'(bus.vram_we), 32'd0);
    chk("rst_addr",     32'(bus.vram_address), 32'd0);
    chk("rst_data",     32'(bus.vram_data), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_busy",     32'(bus.busy), 32'd0);
    chk("rst_ready",    32'(bus.cpu_ready), 32'd1);
    rst = 1'b1;
    tick();

    // 1: single write held off until the window opens
    bus.cpu_valid = 1'b1; bus.cpu_address = 12'h3C0; bus.cpu_data = 8'h5A;
    tick();
    bus.cpu_valid = 1'b0;
    chk("t1_no_bypass", 32'(bus.vram_we), 32'd0);
    chk("t1_busy",      32'(bus.busy), 32'd1);
    tick();
    chk("t1_closed",    32'(bus.vram_we), 32'd0);
    bus.writable = 1'b1;
    tick();
    chk("t1_we",        32'(bus.vram_we), 32'd1);
    chk("t1_addr",      32'(bus.vram_address), 32'h3C0);
    chk("t1_data",      32'(bus.vram_data), 32'h5A);
    chk("t1_busy_fall", 32'(bus.busy), 32'd0);
    tick();
    chk("t1_we_off",    32'(bus.vram_we), 32'd0);
    chk("t1_addr_hold", 32'(bus.vram_address), 32'h3C0);

    // 2: fill FIFO, overflow, drain in order
    bus.writable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.cpu_valid = 1'b1; bus.cpu_address = 12'(12'h100 + i); bus.cpu_data = 8'(8'h10 + i);
      tick();
    end
    chk("t2_ready_full", 32'(bus.cpu_ready), 32'd0);
    chk("t2_no_ovf",     32'(bus.overflow), 32'd0);
    bus.cpu_address = 12'h1FF; bus.cpu_data = 8'hEE;
    tick();
    bus.cpu_valid = 1'b0;
    chk("t2_overflow",   32'(bus.overflow), 32'd1);
    chk("t2_closed",     32'(bus.vram_we), 32'd0);
    bus.writable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t2_we",   32'(bus.vram_we), 32'd1);
      chk("t2_addr", 32'(bus.vram_address), 32'(12'h100 + i));
      chk("t2_data", 32'(bus.vram_data), 32'(8'h10 + i));
    end
    tick();
    chk("t2_dropped",    32'(bus.vram_we), 32'd0);
    chk("t2_busy",       32'(bus.busy), 32'd0);
    chk("t2_ovf_sticky", 32'(bus.overflow), 32'd1);

    // 3: 960-byte fill with the window toggling every 64 cycles
    bus.fill_start = 1'b1; bus.fill_base = 12'h200; bus.fill_len = 12'h3C0; bus.fill_value = 8'h00;
    tick();
    bus.fill_start = 1'b0;
    n = 0;
    ea = 12'h200;
    for (int c = 0; c < 4000 && !(n == 960 && !bus.busy); c++) begin
      bus.writable = ((c / 64) % 2 == 0);
      wprev = bus.writable;
      tick();
      if (bus.vram_we) begin
        chk("t3_gate", 32'(wprev), 32'd1);
        chk("t3_addr", 32'(bus.vram_address), 32'(ea));
        chk("t3_data", 32'(bus.vram_data), 32'h00);
        ea = ea + 1'b1;
        n++;
      end
    end
    bus.writable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.vram_we) n++;
    end
    chk("t3_count", 32'(n), 32'd960);
    chk("t3_busy",  32'(bus.busy), 32'd0);

    // 4: fill wrapping past the top of VRAM
    wrap_addr[0] = 12'hFFE; wrap_addr[1] = 12'hFFF; wrap_addr[2] = 12'h000; wrap_addr[3] = 12'h001;
    bus.fill_start = 1'b1; bus.fill_base = 12'hFFE; bus.fill_len = 12'd4; bus.fill_value = 8'hA5;
    tick();
    bus.fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_we",   32'(bus.vram_we), 32'd1);
      chk("t4_addr", 32'(bus.vram_address), 32'(wrap_addr[i]));
      chk("t4_data", 32'(bus.vram_data), 32'hA5);
    end
    chk("t4_idle",  32'(bus.busy), 32'd0);
    tick();
    chk("t4_we_off", 32'(bus.vram_we), 32'd0);

    // 5: queued writes drain before a deferred fill
    bus.writable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_valid = 1'b1; bus.cpu_address = 12'(12'h010 + i); bus.cpu_data = 8'(8'h11 * (i + 1));
      tick();
    end
    bus.cpu_valid = 1'b0;
    bus.fill_start = 1'b1; bus.fill_base = 12'h020; bus.fill_len = 12'd2; bus.fill_value = 8'h77;
    tick();
    bus.fill_start = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd1);
    chk("t5_closed", 32'(bus.vram_we), 32'd0);
    bus.writable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_q_we",   32'(bus.vram_we), 32'd1);
      chk("t5_q_addr", 32'(bus.vram_address), 32'(12'h010 + i));
      chk("t5_q_data", 32'(bus.vram_data), 32'(8'h11 * (i + 1)));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_f_we",   32'(bus.vram_we), 32'd1);
      chk("t5_f_addr", 32'(bus.vram_address), 32'(12'h020 + i));
      chk("t5_f_data", 32'(bus.vram_data), 32'h77);
    end
    chk("t5_idle", 32'(bus.busy), 32'd0);
    bus.fill_start = 1'b1; bus.fill_base = 12'h300; bus.fill_len = 12'd0; bus.fill_value = 8'hFF;
    tick();
    bus.fill_start = 1'b0;
    chk("t5_len0_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("t5_len0_we",   32'(bus.vram_we), 32'd0);
    chk("t5_len0_busy2", 32'(bus.busy), 32'd0);

    // 5b: push and fill_start on the same IDLE edge
    bus.writable = 1'b0;
    bus.cpu_valid = 1'b1; bus.cpu_address = 12'h040; bus.cpu_data = 8'h44;
    bus.fill_start = 1'b1; bus.fill_base = 12'h030; bus.fill_len = 12'd1; bus.fill_value = 8'h99;
    tick();
    bus.cpu_valid = 1'b0; bus.fill_start = 1'b0;
    bus.writable = 1'b1;
    tick();
    chk("t5b_q_we",   32'(bus.vram_we), 32'd1);
    chk("t5b_q_addr", 32'(bus.vram_address), 32'h040);
    chk("t5b_q_data", 32'(bus.vram_data), 32'h44);
    tick();
    chk("t5b_f_we",   32'(bus.vram_we), 32'd1);
    chk("t5b_f_addr", 32'(bus.vram_address), 32'h030);
    chk("t5b_f_data", 32'(bus.vram_data), 32'h99);
    chk("t5b_idle",   32'(bus.busy), 32'd0);

    // 6: reset mid-fill abandons the remaining work
    bus.fill_start = 1'b1; bus.fill_base = 12'h100; bus.fill_len = 12'h100; bus.fill_value = 8'h05;
    tick();
    bus.fill_start = 1'b0;
    tick();
    tick();
    chk("t6_filling", 32'(bus.vram_we), 32'd1);
    chk("t6_addr",    32'(bus.vram_address), 32'h101);
    rst = 1'b0;
    tick();
    chk("t6_rst_we",   32'(bus.vram_we), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_addr", 32'(bus.vram_address), 32'd0);
    chk("t6_rst_ovf",  32'(bus.overflow), 32'd0);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.vram_we) n++;
    end
    chk("t6_no_writes", 32'(n), 32'd0);
    chk("t6_busy",      32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
